// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode/funct constants, next-PC class encodings
// and the IF/ID queue entry layout.
package cpu_pkg;

  localparam logic [5:0] OP_SPECIAL = 6'b000000;
  localparam logic [5:0] OP_J       = 6'b000010;
  localparam logic [5:0] OP_JAL     = 6'b000011;
  localparam logic [5:0] OP_BEQ     = 6'b000100;
  localparam logic [5:0] FUNCT_JR   = 6'b001000;

  typedef enum logic [2:0] {
    NPC_SEQ    = 3'b000,
    NPC_BRANCH = 3'b001,
    NPC_J      = 3'b010,
    NPC_JAL    = 3'b011,
    NPC_JR     = 3'b100
  } npc_class_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc4;
    logic [2:0]  opclass;
  } fetch_entry_t;

endpackage

// File: rtl/npc_predecode.sv
// Combinational next-PC class decode of one instruction word, using the
// same encodings as the fetch stage's next-PC select.
module npc_predecode
  import cpu_pkg::*;
(
  input  logic [31:0] instr,
  output logic [2:0]  opclass
);

  logic [5:0] opcode;
  logic [5:0] funct;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];

  always_comb begin
    opclass = NPC_SEQ;
    case (opcode)
      OP_BEQ:     opclass = NPC_BRANCH;
      OP_J:       opclass = NPC_J;
      OP_JAL:     opclass = NPC_JAL;
      OP_SPECIAL: if (funct == FUNCT_JR) opclass = NPC_JR;
      default:    opclass = NPC_SEQ;
    endcase
  end

endmodule

// File: rtl/if_id_queue.sv
// Fetch-to-decode queue: circular buffer of fetched instructions with their
// PC+4 and a next-PC class predecoded at push time. Flush beats push/pop.
module if_id_queue
  import cpu_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [31:0]                in_instr,
  input  logic [31:0]                in_pc4,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [31:0]                out_instr,
  output logic [31:0]                out_pc4,
  output logic [2:0]                 out_opclass,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [PTR_W-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0] count_reg, count_next;

  fetch_entry_t entry_mem [DEPTH];
  fetch_entry_t push_entry;
  fetch_entry_t head_entry;
  logic [2:0]   push_opclass;
  logic         push;
  logic         pop;

  npc_predecode u_predecode (
    .instr   (in_instr),
    .opclass (push_opclass)
  );

  // Handshake flags depend only on registered occupancy.
  assign in_ready  = (count_reg < CNT_W'(DEPTH));
  assign out_valid = (count_reg != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  assign push_entry = '{instr: in_instr, pc4: in_pc4, opclass: push_opclass};

  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push)
        wr_ptr_next = (wr_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_reg + PTR_W'(1);
      if (pop)
        rd_ptr_next = (rd_ptr_reg == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_reg + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_next = count_reg + CNT_W'(1);
        2'b01:   count_next = count_reg - CNT_W'(1);
        default: count_next = count_reg;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Storage is not reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (push)
      entry_mem[wr_ptr_reg] <= push_entry;
  end

  assign head_entry  = entry_mem[rd_ptr_reg];
  assign out_instr   = out_valid ? head_entry.instr   : 32'h0;
  assign out_pc4     = out_valid ? head_entry.pc4     : 32'h0;
  assign out_opclass = out_valid ? head_entry.opclass : 3'b000;
  assign count       = count_reg;

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue (DEPTH=2) with hand-computed expectations.
module tb_if_id_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc4;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_instr;
  logic [31:0] out_pc4;
  logic [2:0]  out_opclass;
  logic [1:0]  count;

  int vectors     = 0;
  int miscompares = 0;

  if_id_queue #(.DEPTH(2)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc4      (in_pc4),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_instr   (out_instr),
    .out_pc4     (out_pc4),
    .out_opclass (out_opclass),
    .count       (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_empty(input string tag);
    check({tag, ".count"},     32'(count),       32'd0);
    check({tag, ".out_valid"}, 32'(out_valid),   32'd0);
    check({tag, ".in_ready"},  32'(in_ready),    32'd1);
    check({tag, ".instr"},     out_instr,        32'h0);
    check({tag, ".pc4"},       out_pc4,          32'h0);
    check({tag, ".opclass"},   32'(out_opclass), 32'd0);
  endtask

  task automatic push_one(input logic [31:0] instr, input logic [31:0] pc4);
    in_valid = 1'b1;
    in_instr = instr;
    in_pc4   = pc4;
    tick();
    in_valid = 1'b0;
  endtask

  initial begin
    reset = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc4 = '0;
    flush = 1'b0; out_ready = 1'b0;
    #2;
    check_empty("reset_hold");
    tick();
    tick();
    reset = 1'b1;
    tick();
    check_empty("after_reset");

    // Fill to full with decode stalled
    push_one(32'h10800003, 32'h3004);
    check("fill1.count", 32'(count), 32'd1);
    check("fill1.instr", out_instr, 32'h10800003);
    push_one(32'h08000C00, 32'h3008);
    check("full.count",    32'(count),       32'd2);
    check("full.in_ready", 32'(in_ready),    32'd0);
    check("full.instr",    out_instr,        32'h10800003);
    check("full.pc4",      out_pc4,          32'h3004);
    check("full.opclass",  32'(out_opclass), 32'd1);

    // Offer while full: must be ignored, head stable
    push_one(32'hDEADBEEF, 32'hBEEF);
    check("stall.count",   32'(count),       32'd2);
    check("stall.instr",   out_instr,        32'h10800003);
    check("stall.pc4",     out_pc4,          32'h3004);
    check("stall.opclass", 32'(out_opclass), 32'd1);

    // Drain in order
    out_ready = 1'b1;
    tick();
    check("drain1.count",   32'(count),       32'd1);
    check("drain1.instr",   out_instr,        32'h08000C00);
    check("drain1.pc4",     out_pc4,          32'h3008);
    check("drain1.opclass", 32'(out_opclass), 32'd2);
    tick();
    out_ready = 1'b0;
    check_empty("drain2");

    // Simultaneous push/pop at count=1, pointers wrap several times
    push_one(32'h00000001, 32'h0100);
    check("pp_seed.count", 32'(count), 32'd1);
    for (int i = 0; i < 6; i++) begin
      in_valid  = 1'b1;
      out_ready = 1'b1;
      in_instr  = 32'(i + 2);
      in_pc4    = 32'h0100 + 32'(4 * (i + 1));
      tick();
      check($sformatf("pp%0d.count", i), 32'(count), 32'd1);
      check($sformatf("pp%0d.instr", i), out_instr, 32'(i + 2));
      check($sformatf("pp%0d.pc4", i),   out_pc4,   32'h0100 + 32'(4 * (i + 1)));
    end

    // Flush with push and pop both active at count=1
    in_instr = 32'h0C000C00;
    in_pc4   = 32'h4000;
    flush    = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    check_empty("flush");
    tick();
    check_empty("post_flush");

    // Predecode classes; first push after flush also exercises pointer reset
    push_one(32'h03E00008, 32'h5004);
    check("pd_jr.instr",   out_instr,        32'h03E00008);
    check("pd_jr.opclass", 32'(out_opclass), 32'd4);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    push_one(32'h0C000C00, 32'h5008);
    check("pd_jal.opclass", 32'(out_opclass), 32'd3);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    push_one(32'h00000000, 32'h500C);
    check("pd_nop.valid",   32'(out_valid),   32'd1);
    check("pd_nop.opclass", 32'(out_opclass), 32'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;
    push_one(32'h00000020, 32'h5010);
    check("pd_add.opclass", 32'(out_opclass), 32'd0);
    out_ready = 1'b1; tick(); out_ready = 1'b0;

    // Asynchronous reset mid-cycle with count=2
    push_one(32'h11111111, 32'h6004);
    push_one(32'h22222222, 32'h6008);
    check("pre_rst.count", 32'(count), 32'd2);
    in_valid = 1'b1; out_ready = 1'b1; in_instr = 32'h33333333;
    #2;
    reset = 1'b0;
    #1;
    check_empty("async_rst");
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b0;
    reset = 1'b1;
    push_one(32'h08000001, 32'h7004);
    check("resume.count",   32'(count),       32'd1);
    check("resume.instr",   out_instr,        32'h08000001);
    check("resume.pc4",     out_pc4,          32'h7004);
    check("resume.opclass", 32'(out_opclass), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/if_id_queue.md
IF_ID_QUEUE -- requirements
Module: if_id_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 2, meaning number of buffered fetch entries (legal: 2 or 4).
REQ-002 SHALL have port clk  in  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous active-low reset (reset==0 resets the block immediately, independent of clk).
REQ-004 SHALL have port in_valid  in  1  fetch stage offers an entry this cycle.
REQ-005 SHALL have port in_ready  out  1  queue accepts an entry this cycle.
REQ-006 SHALL have port in_instr  in  32  fetched instruction word.
REQ-007 SHALL have port in_pc4  in  32  PC+4 of the fetched instruction.
REQ-008 SHALL have port flush  in  1  redirect; discard all buffered entries.
REQ-009 SHALL have port out_valid  out  1  head entry available to decode.
REQ-010 SHALL have port out_ready  in  1  decode consumes the head entry this cycle.
REQ-011 SHALL have port out_instr  out  32  head instruction.
REQ-012 SHALL have port out_pc4  out  32  head PC+4.
REQ-013 SHALL have port out_opclass  out  3  predecoded next-PC class of the head instruction.
REQ-014 SHALL have port count  out  clog2(DEPTH)+1  number of occupied entries.

Function
REQ-015 SHALL push when in_valid && in_ready; SHALL pop when out_valid && out_ready.
REQ-016 SHALL drive in_ready = (count < DEPTH), registered-state only, with no combinational path from out_ready or in_valid.
REQ-017 SHALL drive out_valid = (count != 0); no bypass: a push into an empty queue appears at the outputs one cycle later.
REQ-018 SHALL perform push and pop in the same cycle when both qualify, leaving count unchanged.
REQ-019 SHALL implement circular read/write pointers wrapping from DEPTH-1 to 0.
REQ-020 SHALL hold out_instr, out_pc4 and out_opclass stable while out_valid && !out_ready.
REQ-021 SHALL drive out_instr, out_pc4 = 0 and out_opclass = 3'b000 while empty.
REQ-022 SHALL compute opclass at push time and store it with the entry: opcode 6'b000100 -> 3'b001 (branch); 6'b000010 -> 3'b010 (j); 6'b000011 -> 3'b011 (jal); opcode 6'b000000 with funct 6'b001000 -> 3'b100 (jr); all others -> 3'b000 (sequential).
REQ-023 SHALL give flush highest priority: at the clock edge with flush==1, count becomes 0, pointers return to 0, and any same-cycle push and pop are discarded.
REQ-024 SHALL present in_ready==1 and out_valid==0 in the cycle after a flush.
REQ-025 SHALL ignore in_instr/in_pc4 when no push occurs and SHALL never overwrite an occupied entry.

Reset
REQ-026 SHALL, while reset==0, force count=0, pointers=0, out_valid=0, in_ready=1, out_instr=0, out_pc4=0, out_opclass=3'b000.
REQ-027 SHALL abort any in-progress push/pop on reset assertion mid-cycle; storage contents need not be cleared.
REQ-028 SHALL resume normal operation on the first rising clk edge after reset returns to 1.

Structure
REQ-029 SHALL take opcode/funct constants and the 3-bit next-PC class encodings (000 seq, 001 branch, 010 j, 011 jal, 100 jr) from shared package cpu_pkg, the same encodings the fetch stage's next-PC select uses.
REQ-030 SHALL place the opclass decode in one combinational sub-module, npc_predecode (in: instr[31:0]; out: opclass[2:0]).

Verification
REQ-031 Reset: drive reset=0 mid-operation with count=2 -> same cycle count=0, out_valid=0, in_ready=1, outputs 0.
REQ-032 Fill/stall, DEPTH=2: push 0x10800003/0x3004 then 0x08000C00/0x3008 with out_ready=0 -> count=2, in_ready=0, head holds 0x10800003, pc4 0x3004, opclass 001.
REQ-033 Drain order: from REQ-032 state assert out_ready=1 for 2 cycles -> outputs 0x10800003 then 0x08000C00 (opclass 010), then out_valid=0.
REQ-034 Simultaneous push/pop with count=1 over 6 cycles -> count stays 1, pointers wrap, entries emerge in push order.
REQ-035 Flush with push and pop active and count=1 -> next cycle count=0, out_valid=0, pushed entry absent.
REQ-036 Predecode: push 0x03E00008 (jr $ra), 0x0C000C00 (jal), 0x00000000 (nop) -> out_opclass 100, 011, 000 respectively.
